// File: rtl/gif_pkg.sv
// gif_pkg: definitions shared by the GIF frame loader, the frame memory and the
// panel driver.
//   SYNC_BYTE   packet start marker
//   gif_state_t loader FSM state encoding
//   widths      word, pixel index, frame id and memory address widths
//   gif_addr()  builds a frame memory address from a slot id and a pixel index
package gif_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int WORD_W = 24;   // 4 bit-planes x {RGB0,RGB1}
  localparam int PIX_W  = 11;   // {row[4:0], col[5:0]}
  localparam int ID_W   = 2;
  localparam int ADDR_W = ID_W + PIX_W;

  typedef enum logic [2:0] {
    ST_HUNT     = 3'd0,
    ST_FRAME_ID = 3'd1,
    ST_PAYLOAD  = 3'd2,
    ST_CHECK    = 3'd3,
    ST_DONE     = 3'd4
  } gif_state_t;

  function automatic logic [ADDR_W-1:0] gif_addr(input logic [ID_W-1:0] id,
                                                 input logic [PIX_W-1:0] pix);
    return {id, pix};
  endfunction

endpackage

// File: rtl/gif_frame_loader_byte_packer.sv
// byte_packer: assembles three consecutive bytes into one 24-bit pixel word.
//   clk, rst    clock, synchronous active-high reset
//   clr         restart grouping at byte 0 (start of a new payload)
//   byte_vld    byte_data is being accepted this cycle
//   byte_data   incoming byte; first byte lands in word[23:16]
//   word_cmpl   combinational: the accepted byte completes a word
//   vld_p1      registered word-ready strobe, one cycle after the third byte
//   word_p1     registered assembled word
import gif_pkg::*;

module byte_packer (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [7:0]        byte_data,
  output logic              word_cmpl,
  output logic              vld_p1,
  output logic [WORD_W-1:0] word_p1
);

  logic [1:0] idx;
  logic [7:0] b0_p0;
  logic [7:0] b1_p0;

  assign word_cmpl = byte_vld && (idx == 2'd2);

  // Stage p0: byte position tracking and holding of the first two bytes.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      idx <= 2'd0;
    end else if (byte_vld) begin
      idx <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (byte_vld && idx == 2'd0) b0_p0 <= byte_data;
    if (byte_vld && idx == 2'd1) b1_p0 <= byte_data;
  end

  // Stage p1: the completed word and its strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      word_p1 <= '0;
    end else begin
      vld_p1 <= word_cmpl && !clr;
      if (word_cmpl && !clr) word_p1 <= {b0_p0, b1_p0, byte_data};
    end
  end

endmodule

// File: rtl/gif_frame_loader.sv
// gif_frame_loader: parses framed packets from a UART byte stream and writes
// one frame of pixel words into a slot of the shared frame memory.
// Packet: SYNC_BYTE, frame id, 3*WORDS_PER_FRAME payload bytes, XOR checksum.
//   clk, rst                  clock, synchronous active-high reset
//   in_data/in_valid/in_ready byte stream with ready/valid handshake
//   wr_en/wr_addr/wr_data     frame memory write port ({id, pixel}, 24-bit word)
//   frame_valid               per-slot "holds a verified frame" flags
//   frame_done                one-cycle pulse after a verified frame
//   err_cksum/err_id/err_timeout  one-cycle error pulses
import gif_pkg::*;

module gif_frame_loader #(
  parameter int         NUM_FRAMES      = 4,
  parameter int         WORDS_PER_FRAME = 2048,
  parameter logic [7:0] SYNC_BYTE       = gif_pkg::SYNC_BYTE,
  parameter int         TIMEOUT         = 1250000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [WORD_W-1:0]     wr_data,
  output logic [NUM_FRAMES-1:0] frame_valid,
  output logic                  frame_done,
  output logic                  err_cksum,
  output logic                  err_id,
  output logic                  err_timeout
);

  localparam logic [7:0]       NF_B     = 8'(NUM_FRAMES);
  localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(WORDS_PER_FRAME - 1);
  localparam logic [31:0]      IDLE_MAX = 32'(TIMEOUT - 1);

  gif_state_t      state, state_nxt;
  logic            accept;
  logic [ID_W-1:0] id_q;
  logic [PIX_W-1:0] pix_cnt;
  logic [7:0]      cksum;
  logic [31:0]     idle_cnt;
  logic            counting, timed_out;
  logic            ev_id_ok, ev_id_err, ev_ck_ok, ev_ck_err;
  logic            pay_byte, word_cmpl;

  assign counting  = (state == ST_FRAME_ID) || (state == ST_PAYLOAD) || (state == ST_CHECK);
  assign timed_out = counting && !accept && (idle_cnt >= IDLE_MAX);
  assign pay_byte  = accept && (state == ST_PAYLOAD);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_HUNT;
    else     state <= state_nxt;
  end

  // Next-state logic; also flags the packet events the datapath reacts to.
  always_comb begin
    state_nxt = state;
    ev_id_ok  = 1'b0;
    ev_id_err = 1'b0;
    ev_ck_ok  = 1'b0;
    ev_ck_err = 1'b0;
    case (state)
      ST_HUNT:
        if (accept && in_data == SYNC_BYTE) state_nxt = ST_FRAME_ID;
      ST_FRAME_ID:
        if (accept) begin
          if (in_data < NF_B) begin
            ev_id_ok  = 1'b1;
            state_nxt = ST_PAYLOAD;
          end else begin
            ev_id_err = 1'b1;
            state_nxt = ST_HUNT;
          end
        end
      ST_PAYLOAD:
        if (word_cmpl && pix_cnt == LAST_PIX) state_nxt = ST_CHECK;
      ST_CHECK:
        if (accept) begin
          if (in_data == cksum) begin
            ev_ck_ok  = 1'b1;
            state_nxt = ST_DONE;
          end else begin
            ev_ck_err = 1'b1;
            state_nxt = ST_HUNT;
          end
        end
      ST_DONE:
        state_nxt = ST_HUNT;
      default:
        state_nxt = ST_HUNT;
    endcase
    if (timed_out) state_nxt = ST_HUNT;
  end

  // Outputs decoded from state; ready drops while rst is held.
  always_comb begin
    in_ready   = !rst && (state != ST_DONE);
    accept     = in_valid && in_ready;
    frame_done = (state == ST_DONE);
  end

  // Packet datapath: id, pixel counter, checksum, idle timer, slot flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      id_q        <= '0;
      pix_cnt     <= '0;
      cksum       <= '0;
      idle_cnt    <= '0;
      wr_addr     <= '0;
      frame_valid <= '0;
      err_cksum   <= 1'b0;
      err_id      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_cksum   <= ev_ck_err;
      err_id      <= ev_id_err;
      err_timeout <= timed_out;

      if (accept || !counting || timed_out) idle_cnt <= '0;
      else                                  idle_cnt <= idle_cnt + 32'd1;

      if (ev_id_ok) begin
        id_q                         <= in_data[ID_W-1:0];
        frame_valid[in_data[ID_W-1:0]] <= 1'b0;
        pix_cnt                      <= '0;
        cksum                        <= in_data;
      end

      if (pay_byte) cksum <= cksum ^ in_data;

      // Address is registered alongside the packer's word so both land together;
      // the counter parks on the last pixel instead of wrapping.
      if (word_cmpl) begin
        wr_addr <= gif_addr(id_q, pix_cnt);
        if (pix_cnt != LAST_PIX) pix_cnt <= pix_cnt + 1'b1;
      end

      if (ev_ck_ok) frame_valid[id_q] <= 1'b1;
    end
  end

  byte_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (ev_id_ok),
    .byte_vld  (pay_byte),
    .byte_data (in_data),
    .word_cmpl (word_cmpl),
    .vld_p1    (wr_en),
    .word_p1   (wr_data)
  );

endmodule
